pong_game_ctrl: RTL and testbench

Top-level game sequencer for the pong design. Tracks game phase (new game, play, new ball, game over), owns the remaining-ball count and a refresh-tick based delay timer, and drives the clear/increment strobes of the two-digit BCD score counter. It sits between the input debouncers, the ball/paddle graphics engine (hit/miss events, freeze control) and the text overlay (phase and ball count).

---
 rtl/pong_pkg.sv | 6 +
 rtl/pong_timer.sv | 26 ++
 rtl/pong_game_ctrl.sv | 83 ++++++++
 tb/tb_pong_game_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared game phase encoding and default game constants.
package pong_pkg;
    typedef enum logic [1:0] {NEWGAME, PLAY, NEWBALL, OVER} game_state_t;
    localparam int BALLS_DEF       = 3;
    localparam int TIMER_TICKS_DEF = 120;
endpackage

// File: rtl/pong_timer.sv
// pong_timer: refresh-tick delay counter; load wins over decrement, saturates at zero.
module pong_timer
    import pong_pkg::*;
#(
    parameter int TICKS = TIMER_TICKS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic refr_tick_i,
    output logic done_o
);
    localparam int W = $clog2(TICKS + 1);

    logic [W-1:0] count_q, count_d;

    always_comb
        count_d = load_i ? W'(TICKS) :
                  (refr_tick_i && count_q != '0) ? count_q - 1'b1 : count_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;

    assign done_o = (count_q == '0);
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game phase sequencer owning the ball count, delay timer and score strobes.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS       = BALLS_DEF,
    parameter int TIMER_TICKS = TIMER_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    input  logic       refr_tick,
    output logic       d_inc,
    output logic       d_clr,
    output logic       gra_still,
    output logic [1:0] game_state,
    output logic [3:0] balls_left
);
    game_state_t state_q;
    logic [3:0]  balls_q;
    logic        still_q, inc_q, clr_q;
    logic        timer_load, timer_done, pressed;

    assign pressed    = (btn != 2'b00);
    assign timer_load = (state_q == PLAY) && miss;

    pong_timer #(.TICKS(TIMER_TICKS)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (timer_load),
        .refr_tick_i(refr_tick),
        .done_o     (timer_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= NEWGAME;
            balls_q <= 4'(BALLS);
            still_q <= 1'b1;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            inc_q <= 1'b0;
            clr_q <= 1'b0;
            case (state_q)
                NEWGAME:
                    if (pressed) begin
                        state_q <= PLAY;
                        balls_q <= 4'(BALLS - 1);
                        still_q <= 1'b0;
                        clr_q   <= 1'b1;
                    end
                PLAY:
                    // miss outranks a coincident hit, so that hit scores nothing
                    if (miss) begin
                        still_q <= 1'b1;
                        if (balls_q == 4'd0) state_q <= OVER;
                        else begin
                            state_q <= NEWBALL;
                            balls_q <= balls_q - 4'd1;
                        end
                    end else if (hit) inc_q <= 1'b1;
                NEWBALL:
                    if (timer_done && pressed) begin
                        state_q <= PLAY;
                        still_q <= 1'b0;
                    end
                OVER:
                    if (timer_done) begin
                        state_q <= NEWGAME;
                        balls_q <= 4'(BALLS);
                    end
            endcase
        end
    end

    assign game_state = state_q;
    assign balls_left = balls_q;
    assign gra_still  = still_q;
    assign d_inc      = inc_q;
    assign d_clr      = clr_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed test-plan walk plus random play, checked against a phase-level game model.
module tb_pong_game_ctrl;
    localparam int NB = 3;
    localparam int NT = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       hit = 1'b0, miss = 1'b0, refr_tick = 1'b0;
    logic       d_inc, d_clr, gra_still;
    logic [1:0] game_state;
    logic [3:0] balls_left;

    int n_cmp = 0;
    int n_bad = 0;

    // model: phase 0 new game, 1 play, 2 new ball, 3 over
    int m_phase, m_balls, m_timer, m_inc, m_clr;

    pong_game_ctrl #(.BALLS(NB), .TIMER_TICKS(NT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn       (btn),
        .hit       (hit),
        .miss      (miss),
        .refr_tick (refr_tick),
        .d_inc     (d_inc),
        .d_clr     (d_clr),
        .gra_still (gra_still),
        .game_state(game_state),
        .balls_left(balls_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".state"}, int'(game_state), m_phase);
        chk({tag, ".balls"}, int'(balls_left), m_balls);
        chk({tag, ".still"}, int'(gra_still), (m_phase == 1) ? 0 : 1);
        chk({tag, ".inc"}, int'(d_inc), m_inc);
        chk({tag, ".clr"}, int'(d_clr), m_clr);
        chk({tag, ".timer"}, int'(dut.u_timer.count_q), m_timer);
    endtask

    task automatic model_reset();
        m_phase = 0; m_balls = NB; m_timer = 0; m_inc = 0; m_clr = 0;
    endtask

    // one clock of game rules, judged on the values seen just before the edge
    task automatic model_edge(input int b, input int h, input int m, input int t);
        int nt;
        nt = (t != 0 && m_timer > 0) ? m_timer - 1 : m_timer;
        m_inc = 0;
        m_clr = 0;
        if (m_phase == 0 && b != 0) begin
            m_phase = 1; m_clr = 1; m_balls = NB - 1;
        end else if (m_phase == 1 && m != 0) begin
            nt = NT;
            if (m_balls == 0) m_phase = 3;
            else begin m_phase = 2; m_balls--; end
        end else if (m_phase == 1 && h != 0) m_inc = 1;
        else if (m_phase == 2 && m_timer == 0 && b != 0) m_phase = 1;
        else if (m_phase == 3 && m_timer == 0) begin m_phase = 0; m_balls = NB; end
        m_timer = nt;
    endtask

    task automatic step(input string tag, input int b, input int h, input int m, input int t);
        btn = 2'(b); hit = 1'(h); miss = 1'(m); refr_tick = 1'(t);
        @(posedge clk);
        model_edge(b, h, m, t);
        #1;
        chk_all(tag);
        @(negedge clk);
        btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk_all("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk_all("idle0");
        step("start", 1, 0, 0, 0);
        step("start_after", 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step("hit", 0, 1, 0, 0);
            step("hit_gap", 0, 0, 0, 0);
        end
        step("hit_miss", 0, 1, 1, 0);
        step("nb_t1", 0, 0, 0, 1);
        step("nb_t2", 0, 0, 0, 1);
        step("nb_early_btn", 2, 0, 0, 0);
        step("nb_t3", 0, 0, 0, 1);
        step("nb_t4", 0, 0, 0, 1);
        step("nb_btn", 3, 0, 0, 0);
        step("miss_tick", 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step("nb2_tick", 0, 0, 0, 1);
        step("nb2_early_btn", 1, 0, 0, 0);
        step("nb2_t4", 0, 0, 0, 1);
        step("nb2_btn", 1, 0, 0, 0);
        step("miss_over", 0, 0, 1, 0);
        step("over_btn", 3, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("over_tick", 2, 1, 1, 1);
        step("over_exit", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("newgame_idle", 0, 1, 1, 1);
        step("restart", 2, 0, 0, 0);
        step("miss_r", 0, 0, 1, 0);
        step("tick_r", 0, 0, 0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_all("after_reset");
        for (int i = 0; i < 3000; i++)
            step("rand", ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0,
                 ($urandom_range(0, 2) == 0) ? 1 : 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
